// File: rtl/npu_adder_pkg.sv
// npu_adder_pkg: shared constants and stage-count helper for the pipelined CLA adder.
package npu_adder_pkg;

   localparam int GROUP_W = 4;

   function automatic int STAGES(input int width, input int groups_per_stage);
      return width / (GROUP_W * groups_per_stage);
   endfunction

endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group with group propagate/generate.
module cla_group4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       gp,
   output logic       gg,
   output logic       co
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:1] c;

   always_comb begin
      p    = x ^ y;
      g    = x & y;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & ci);
      gg   = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
      gp   = &p;
      co   = gg | (gp & ci);
      s    = p ^ {c, ci};
   end

endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined carry-lookahead add/subtract with saturation and a global stall.
module pipe_cla_adder
   import npu_adder_pkg::*;
#(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NG  = WIDTH / GROUP_W;
   localparam int GPS = GROUPS_PER_STAGE;
   localparam int NS  = STAGES(WIDTH, GROUPS_PER_STAGE);

   logic [WIDTH-1:0] x_q [NS];
   logic [WIDTH-1:0] y_q [NS];
   logic [WIDTH-1:0] s_q [NS];
   logic [WIDTH-1:0] x_d [NS];
   logic [WIDTH-1:0] y_d [NS];
   logic [WIDTH-1:0] s_in [NS];
   logic [WIDTH-1:0] s_d [NS];
   logic [NS-1:0]    v_q, v_d, c_q, c_d, c_in, sat_q, sat_d;
   logic [WIDTH-1:0] gs;
   logic [NG-1:0]    gp, gg, gc, gco;
   logic             advance;
   logic             unused_co;

   assign advance   = !v_q[NS-1] || out_ready;
   assign in_ready  = advance;
   // Group carry-outs duplicate the lookahead carries, which are used instead.
   assign unused_co = ^gco;

   // Subtraction travels down the pipe as an inverted operand plus forced carry-in.
   always_comb begin
      x_d[0]   = a;
      y_d[0]   = sub ? ~b : b;
      s_in[0]  = '0;
      c_in     = '0;
      c_in[0]  = sub | cin;
      v_d      = '0;
      v_d[0]   = in_valid;
      sat_d    = '0;
      sat_d[0] = sat;
      for (int k = 1; k < NS; k++) begin
         x_d[k]   = x_q[k-1];
         y_d[k]   = y_q[k-1];
         s_in[k]  = s_q[k-1];
         c_in[k]  = c_q[k-1];
         v_d[k]   = v_q[k-1];
         sat_d[k] = sat_q[k-1];
      end
   end

   for (genvar j = 0; j < NG; j++) begin : g_grp
      localparam int K = j / GPS;
      cla_group4 u_grp (
         .x  (x_d[K][j*GROUP_W +: GROUP_W]),
         .y  (y_d[K][j*GROUP_W +: GROUP_W]),
         .ci (gc[j]),
         .s  (gs[j*GROUP_W +: GROUP_W]),
         .gp (gp[j]),
         .gg (gg[j]),
         .co (gco[j])
      );
   end

   // Sum-of-products lookahead from the stage carry-in; the last term is the stage carry-out.
   always_comb begin
      gc  = '0;
      c_d = '0;
      for (int k = 0; k < NS; k++) begin
         for (int j = k*GPS; j <= (k+1)*GPS; j++) begin
            logic c;
            logic pr;
            c  = 1'b0;
            pr = 1'b1;
            for (int i = j-1; i >= k*GPS; i--) begin
               c  = c | (gg[i] & pr);
               pr = pr & gp[i];
            end
            c = c | (pr & c_in[k]);
            if (j < (k+1)*GPS) gc[j] = c;
            else c_d[k] = c;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NS; k++) begin
         s_d[k] = s_in[k];
         for (int j = k*GPS; j < (k+1)*GPS; j++) s_d[k][j*GROUP_W +: GROUP_W] = gs[j*GROUP_W +: GROUP_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         sat_q <= '0;
         x_q   <= '{default: '0};
         y_q   <= '{default: '0};
         s_q   <= '{default: '0};
      end else if (advance) begin
         v_q   <= v_d;
         c_q   <= c_d;
         sat_q <= sat_d;
         x_q   <= x_d;
         y_q   <= y_d;
         s_q   <= s_d;
      end
   end

   always_comb begin
      out_valid = v_q[NS-1];
      cout      = c_q[NS-1];
      ovf       = s_q[NS-1][WIDTH-1] ^ x_q[NS-1][WIDTH-1] ^ y_q[NS-1][WIDTH-1] ^ c_q[NS-1];
      sum       = (sat_q[NS-1] && ovf) ? {x_q[NS-1][WIDTH-1], {(WIDTH-1){~x_q[NS-1][WIDTH-1]}}} : s_q[NS-1];
   end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4, minimum 8.
REQ-002 Parameter GROUPS_PER_STAGE, default 1, number of 4-bit CLA groups resolved per pipeline stage; SHALL divide WIDTH/4; STAGES = WIDTH/(4*GROUPS_PER_STAGE).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand transaction present.
REQ-006 in_ready  output  1  block accepts transaction this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (ignored in subtract mode).
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 sat  input  1  1 = clamp result on signed overflow.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result this cycle.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 cout  output  1  carry-out of MSB (unsigned carry; in subtract, 1 = no borrow).
REQ-016 ovf  output  1  signed overflow of the unsaturated result.

Function
REQ-017 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 Stage k (0..STAGES-1) SHALL resolve groups k*GROUPS_PER_STAGE..(k+1)*GROUPS_PER_STAGE-1 using group carry-lookahead (p = x^y, g = x&y) with carry-in from the stage-(k-1) registered carry; stage 0 uses cin, or 1 when sub=1.
REQ-019 Operand bits of not-yet-resolved groups SHALL be delayed in skew registers; resolved sum bits SHALL be carried forward in deskew registers so all WIDTH bits emerge aligned.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-021 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-022 Global stall: advance = !out_valid || out_ready; in_ready = advance; when advance=0 every stage register and valid bit SHALL hold.
REQ-023 Each stage SHALL carry a valid bit; a bubble (no transfer) SHALL propagate as valid=0 and never produce out_valid.
REQ-024 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB of the unsaturated result.
REQ-025 When sat=1 and ovf=1, sum SHALL be 0x7F..F if operand A MSB=0, else 0x80..0; cout and ovf report the unsaturated values.
REQ-026 sub and sat SHALL travel with the transaction through the pipeline (per-transaction, not global).
REQ-027 Results SHALL leave in input order; none dropped or duplicated under any stall pattern.
REQ-028 sum, cout, ovf SHALL be stable while out_valid && !out_ready.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 Transactions in flight at reset SHALL be discarded; no result for them appears after release.

Structure
REQ-032 Package npu_adder_pkg SHALL hold GROUP_W=4 and the stage-count function STAGES(WIDTH, GROUPS_PER_STAGE).
REQ-033 One sub-module cla_group4 SHALL implement a combinational 4-bit lookahead group (sum, group P, group G, carry-out); instantiated WIDTH/4 times.
REQ-034 Inter-group carry within a stage SHALL use group P/G lookahead, not ripple through cla_group4 carry-outs.

Verification (WIDTH=16, GROUPS_PER_STAGE=1, STAGES=4)
REQ-035 a=0x00FF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
REQ-036 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (full-width carry through all stages).
REQ-037 a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1, sat=1 -> sum=0x8000, ovf=1.
REQ-038 a=0x7FFF, b=0x0001, sat=1 -> sum=0x7FFF, ovf=1; same with sat=0 -> sum=0x8000, ovf=1.
REQ-039 8 back-to-back random transactions, out_ready low for 3 cycles mid-stream -> in_ready low during stall, 8 results in order, all matching the reference model.
REQ-040 3 transactions in flight, rst_n pulsed low -> out_valid=0 asynchronously, no results emitted after release, next transaction returns with 4-cycle latency.
